// File: rtl/wb_stage_if.sv
// MEM->WB payload, data-SRAM return, regfile write port and trace debug bus for wb_stage.
// slave is the stage side; master is whoever drives MEM and observes commits.
interface wb_stage_if;
  logic        mem_valid;
  logic        mem_wen;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_result;
  logic [2:0]  mem_ltype;
  logic [31:0] mem_rt_data;
  logic [31:0] mem_pc;
  logic        stall_mem;
  logic        flush;
  logic [31:0] data_rdata;
  logic        data_ok;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wb_stallreq;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  modport slave (
    input  mem_valid, mem_wen, mem_waddr, mem_result, mem_ltype, mem_rt_data, mem_pc,
    input  stall_mem, flush, data_rdata, data_ok,
    output we, waddr, wdata, wb_stallreq,
    output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport master (
    output mem_valid, mem_wen, mem_waddr, mem_result, mem_ltype, mem_rt_data, mem_pc,
    output stall_mem, flush, data_rdata, data_ok,
    input  we, waddr, wdata, wb_stallreq,
    input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB register, load-data extraction/merge and regfile commit.
// Stalls the pipeline while a captured load still waits for its data_ok pulse.
//
// state   | meaning
// --------+------------------------------------------------------------
// PS_IDLE | WB holds a bubble or a non-load; nothing outstanding
// PS_WAIT | WB holds a valid load whose data word has not yet returned
module wb_stage (
  input  logic       clk,
  input  logic       resetn,
  wb_stage_if.slave  bus
);

  typedef enum logic {PS_IDLE, PS_WAIT} pend_state_t;

  localparam logic [2:0] LT_NONE = 3'd0;
  localparam logic [2:0] LT_LB   = 3'd1;
  localparam logic [2:0] LT_LBU  = 3'd2;
  localparam logic [2:0] LT_LH   = 3'd3;
  localparam logic [2:0] LT_LHU  = 3'd4;
  localparam logic [2:0] LT_LW   = 3'd5;
  localparam logic [2:0] LT_LWL  = 3'd6;
  localparam logic [2:0] LT_LWR  = 3'd7;

  pend_state_t state, state_nxt;

  logic        valid_q;
  logic        wen_q;
  logic [4:0]  waddr_q;
  logic [31:0] result_q;
  logic [2:0]  ltype_q;
  logic [31:0] rt_data_q;
  logic [31:0] pc_q;

  logic        stallreq;
  logic        capture_valid;
  logic        cmt;
  logic        we_int;
  logic [31:0] wdata_int;
  logic [3:0]  mask_int;

  // A held load ignores flush/stall_mem: it is already ordered for commit.
  assign stallreq      = valid_q & (state == PS_WAIT) & ~bus.data_ok;
  assign capture_valid = bus.mem_valid & ~bus.flush & ~bus.stall_mem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= PS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!stallreq) begin
      if (capture_valid && (bus.mem_ltype != LT_NONE)) begin
        state_nxt = PS_WAIT;
      end else begin
        state_nxt = PS_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q   <= 1'b0;
      wen_q     <= 1'b0;
      waddr_q   <= 5'd0;
      result_q  <= 32'd0;
      ltype_q   <= LT_NONE;
      rt_data_q <= 32'd0;
      pc_q      <= 32'd0;
    end else if (!stallreq) begin
      if (capture_valid) begin
        valid_q   <= 1'b1;
        wen_q     <= bus.mem_wen;
        waddr_q   <= bus.mem_waddr;
        result_q  <= bus.mem_result;
        ltype_q   <= bus.mem_ltype;
        rt_data_q <= bus.mem_rt_data;
        pc_q      <= bus.mem_pc;
      end else begin
        valid_q   <= 1'b0;
        wen_q     <= 1'b0;
        waddr_q   <= 5'd0;
        result_q  <= 32'd0;
        ltype_q   <= LT_NONE;
        rt_data_q <= 32'd0;
        pc_q      <= 32'd0;
      end
    end
  end

  logic [1:0]  k;
  logic [1:0]  kl;
  logic [4:0]  sh_r;
  logic [4:0]  sh_l;
  logic [31:0] m_shr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign k       = result_q[1:0];
  assign kl      = 2'd3 - k;
  assign sh_r    = {k, 3'b000};
  assign sh_l    = {kl, 3'b000};
  assign m_shr   = bus.data_rdata >> sh_r;
  assign ld_byte = m_shr[7:0];
  assign ld_half = k[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];

  always_comb begin
    wdata_int = result_q;
    mask_int  = 4'b1111;
    case (ltype_q)
      LT_LB:  wdata_int = {{24{ld_byte[7]}}, ld_byte};
      LT_LBU: wdata_int = {24'd0, ld_byte};
      LT_LH:  wdata_int = {{16{ld_half[15]}}, ld_half};
      LT_LHU: wdata_int = {16'd0, ld_half};
      LT_LW:  wdata_int = bus.data_rdata;
      LT_LWL: begin
        wdata_int = (bus.data_rdata << sh_l) | (rt_data_q & ~(32'hFFFF_FFFF << sh_l));
        mask_int  = 4'b1111 << kl;
      end
      LT_LWR: begin
        wdata_int = m_shr | (rt_data_q & ~(32'hFFFF_FFFF >> sh_r));
        mask_int  = 4'b1111 >> k;
      end
      default: begin
        wdata_int = result_q;
        mask_int  = 4'b1111;
      end
    endcase
  end

  assign cmt    = valid_q & ((ltype_q == LT_NONE) | bus.data_ok);
  assign we_int = cmt & wen_q & (waddr_q != 5'd0);

  assign bus.we                = we_int;
  assign bus.waddr             = waddr_q;
  assign bus.wdata             = wdata_int;
  assign bus.wb_stallreq       = stallreq;
  assign bus.debug_wb_pc       = valid_q ? pc_q : 32'd0;
  assign bus.debug_wb_rf_wen   = we_int ? mask_int : 4'b0000;
  assign bus.debug_wb_rf_wnum  = waddr_q;
  assign bus.debug_wb_rf_wdata = wdata_int;

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the 5-stage MIPS pipeline: the MEM/WB pipeline register plus load-data extraction. It drives the regfile write port (`we`/`waddr`/`wdata`), so the regfile's WB bypass sees exactly the value being committed. It also drives the NSCSCC trace debug outputs. For loads it waits on the data-SRAM `data_ok` handshake and raises `wb_stallreq` while the returned word is outstanding.

## Interface
- No parameters.
- `clk`  in  1  pipeline clock, rising edge
- `resetn`  in  1  asynchronous active-low reset
- `mem_valid`  in  1  MEM holds a real instruction
- `mem_wen`  in  1  instruction writes a GPR
- `mem_waddr`  in  5  destination GPR
- `mem_result`  in  32  ALU result / load address (bits [1:0] used for loads)
- `mem_ltype`  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR
- `mem_rt_data`  in  32  old rt value, merge source for LWL/LWR
- `mem_pc`  in  32  instruction PC
- `stall_mem`  in  1  MEM not advancing this cycle
- `flush`  in  1  pipeline flush
- `data_rdata`  in  32  data-SRAM read word
- `data_ok`  in  1  `data_rdata` valid this cycle (1-cycle pulse)
- `we`  out  1  regfile write enable
- `waddr`  out  5  regfile write address
- `wdata`  out  32  regfile write data
- `wb_stallreq`  out  1  WB waiting on load data; freezes the pipeline
- `debug_wb_pc`  out  32  committed PC
- `debug_wb_rf_wen`  out  4  committed byte mask
- `debug_wb_rf_wnum`  out  5  committed GPR
- `debug_wb_rf_wdata`  out  32  committed data

## Operation
- Internal register holds: `valid`, `wen`, `waddr`, `result`, `ltype`, `rt_data`, `pc`, and `pending` (load awaiting `data_ok`).
- Capture at each rising edge, in priority order:
  - If `wb_stallreq` is high, hold all state.
  - Otherwise, if `flush` or `stall_mem` is high, load a bubble (`valid`=0).
  - Otherwise, load the MEM inputs.
- `pending` is set on capture of a valid load (`ltype`≠0). It clears in the cycle `data_ok`=1.
- `wb_stallreq` = `valid` & `pending` & ~`data_ok`. This is combinational, so the commit and the release happen in the same cycle.
- Commit condition `cmt` = `valid` & (`ltype`==0 | `data_ok`).
- `we` = `cmt` & `wen` & (`waddr`≠0).
- Load extraction, with k = `result[1:0]` and m = `data_rdata` (little-endian):
  - LB / LBU: byte k, sign-extended / zero-extended.
  - LH / LHU: halfword `k[1]`, sign-extended / zero-extended. `k[0]` is ignored; alignment exceptions are raised upstream.
  - LW: m.
  - LWL: (m << 8·(3−k)) | (`rt_data` & ~(32'hFFFFFFFF << 8·(3−k))). Mask = 4'b1111 << (3−k).
  - LWR: (m >> 8·k) | (`rt_data` & ~(32'hFFFFFFFF >> 8·k)). Mask = 4'b1111 >> k.
  - Mask for all other types = 4'b1111.
- `ltype`==0: `wdata` = `result`.
- Debug outputs:
  - `debug_wb_rf_wen` = mask when `we`=1, else 0.
  - `debug_wb_rf_wnum` = `waddr`; `debug_wb_rf_wdata` = `wdata`.
  - `debug_wb_pc` = `pc` while `valid`, else 0.
- A `flush` while `wb_stallreq`=1 is ignored by WB. The held load is already committed-ordered and still completes.

## Timing
- Reset (`resetn`=0, asynchronous): all state cleared. `we`, `waddr`, `wdata`, `wb_stallreq` and all debug outputs are 0 immediately, without waiting for a clock edge.
- Non-load latency: the instruction is captured at edge N and `we`/`wdata` are valid during cycle N+1.
- Load latency:
  - With `data_ok` in the first WB cycle: commits in that cycle, no stall.
  - Each cycle without `data_ok`: adds one `wb_stallreq` cycle.
- `data_ok` while `valid`=0 or `ltype`=0 is ignored.
- Back-to-back instructions commit on consecutive cycles when no stall is present.
- Deasserting `resetn` mid-wait drops the pending load. A stray `data_ok` afterwards is ignored.

## Test plan
- ADDU result 0x12345678 to r5, no stalls → one cycle after capture: `we`=1, `waddr`=5, `wdata`=0x12345678, `debug_wb_rf_wen`=4'hF.
- LB, addr low bits 2, `data_rdata`=0x0080FF11, `data_ok` in the first cycle → `wdata`=0xFFFFFF80; same case with LBU → 0x00000080.
- LWL k=1, rt=0xAABBCCDD, m=0x11223344 → `wdata`=0x3344CCDD, mask 4'b1100. LWR k=1 with the same values → 0xAA112233, mask 4'b0111.
- LW with `data_ok` delayed 3 cycles → `wb_stallreq`=1 for 3 cycles, `we`=0 throughout; in the `data_ok` cycle `we`=1 and `wb_stallreq`=0; the next MEM instruction then commits on the following cycle.
- `stall_mem`=1 for 2 cycles, then `flush` with a valid MEM instruction → WB sees 3 bubbles: `we`=0, `debug_wb_pc`=0.
- Write to r0 → `we`=0, `debug_wb_rf_wen`=0. Reset asserted mid load wait → all outputs 0 asynchronously; `data_ok` after release produces no write.
